grey_10_check: RTL and testbench
================================

// Module: grey_10_check
// PURPOSE
//  Consumer stage for the ring-grey decade counter. Registers its 5-bit code and divided clock,
//  decodes the code to a BCD digit, and checks every transition: legal code, +1 mod 10 step,
//  and clk_div phase. Lock state, decade carry and a saturating error count feed the next decade.
// PARAMETERS
//  LOCK_N  4  consecutive good transitions needed to enter LOCKED (legal 1..15)
//  ERR_W   8  width of error counter
// PORTS
//  i_clk      in   1      clock; all state on rising edge
//  i_rst      in   1      reset, asynchronous, active-high
//  i_cnt      in   5      ring-grey code from counter
//  i_clk_div  in   1      divide-by-10 clock from counter
//  i_clr_err  in   1      synchronous clear of o_err_cnt
//  o_digit    out  4      decoded digit 0..9; 4'hF when code illegal
//  o_valid    out  1      registered code is one of the 10 legal codes
//  o_locked   out  1      checker in LOCKED state
//  o_carry    out  1      1-cycle pulse on 9->0 transition while LOCKED
//  o_err      out  1      1-cycle pulse on any bad transition while LOCKED
//  o_err_cnt  out  ERR_W  saturating count of o_err pulses
// BEHAVIOUR
//  Code table: 0=10001 1=00001 2=00011 3=00010 4=00110 5=00100 6=01100 7=01000 8=11000 9=10000;
//   all other 22 codes illegal.
//  Reset (async): r_code=r_prev=5'b00000, r_div=0, state=SEARCH, good count=0; outputs:
//   o_digit=4'hF, o_valid=0, o_locked=0, o_carry=0, o_err=0, o_err_cnt=0.
//  Stage 1 (edge N): r_prev<=r_code, r_code<=i_cnt, r_div<=i_clk_div.
//  Stage 2 (edge N+1): outputs registered from stage-1 values -> latency 2 edges from i_cnt.
//  Good transition = r_code legal AND r_prev legal AND dig(r_code)==(dig(r_prev)+1) mod 10
//   AND r_div==(dig(r_code)>=5). A held code (no step) is a bad transition.
//  Initial r_prev after reset is illegal, so the first transition is always bad.
//  FSM SEARCH: good -> good count+1; bad -> good count=0; no o_err, no count.
//   When good count reaches LOCK_N: state=LOCKED, o_locked=1 at that same edge.
//  FSM LOCKED: good -> stay; o_carry=1 iff dig(r_prev)==9 and dig(r_code)==0.
//   bad -> o_err=1 for 1 cycle, o_err_cnt+1 (saturate at all-ones), state=SEARCH,
//   good count=0, o_locked=0 at the same edge. No carry on the lock-entry edge.
//  o_err_cnt: i_clr_err clears to 0; if o_err asserts same cycle, result is 1.
//   At all-ones further errors leave it at all-ones (o_err still pulses).
//  o_digit/o_valid track r_code every cycle regardless of state.
//  Counter start-up (ZERO held, clk_div=1) is absorbed in SEARCH without errors.
//  Reset asserted mid-operation: immediate return to reset values, no partial pulse.
// TESTING
//  T1 reset, then drive legal sequence 0,1,2..9,0.. with correct clk_div -> o_locked rises
//     2+LOCK_N edges after first sample (first edge is bad); o_carry every 10 cycles; o_err_cnt=0.
//  T2 locked, inject illegal 5'b00101 for 1 cycle -> o_valid=0, o_digit=F, o_err pulse,
//     o_err_cnt=1, o_locked=0; relocks after LOCK_N+1 good transitions (illegal breaks 2).
//  T3 locked, skip 3->5 (code 00010 then 00100) -> o_err pulse, err_cnt+1, no o_carry.
//  T4 locked, force i_clk_div=0 while digit 7 -> o_err pulse, unlock.
//  T5 ERR_W=2, cause 5 errors -> o_err_cnt 1,2,3,3,3; i_clr_err with error -> 1; alone -> 0.
//  T6 drive from real counter with its i_rst held 3 cycles, then assert checker i_rst while
//     LOCKED -> all outputs to reset values asynchronously; relock without any o_err.

Source files
------------

// File: rtl/grey_10_check.sv
// grey_10_check: consumer/checker stage for the ring-grey decade counter.
//   Registers the incoming 5-bit ring-grey code and the divided clock. It decodes
//   the registered code to a BCD digit. Every transition is checked for a legal
//   code, a +1 mod 10 step and the correct clk_div phase. Lock state, decade carry
//   and a saturating error count feed the next decade.
// Ports:
//   i_clk      clock, all state on rising edge
//   i_rst      asynchronous active-high reset
//   i_cnt      ring-grey code from the counter
//   i_clk_div  divide-by-10 clock from the counter
//   i_clr_err  synchronous clear of o_err_cnt
//   o_digit    decoded digit 0..9, 4'hF when the registered code is illegal
//   o_valid    registered code is one of the ten legal codes
//   o_locked   checker is in LOCKED
//   o_carry    1-cycle pulse on a 9->0 transition while LOCKED
//   o_err      1-cycle pulse on a bad transition while LOCKED
//   o_err_cnt  saturating count of o_err pulses
module grey_10_check #(
    parameter int unsigned LOCK_N = 4,
    parameter int unsigned ERR_W  = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [4:0]       i_cnt,
    input  logic             i_clk_div,
    input  logic             i_clr_err,
    output logic [3:0]       o_digit,
    output logic             o_valid,
    output logic             o_locked,
    output logic             o_carry,
    output logic             o_err,
    output logic [ERR_W-1:0] o_err_cnt
);

    localparam int unsigned CODE_W = 5;
    localparam int unsigned DIG_W  = 4;
    localparam int unsigned GCNT_W = 4;

    localparam logic [DIG_W-1:0]  DIG_BAD   = DIG_W'(15);
    localparam logic [GCNT_W-1:0] LOCK_LAST = GCNT_W'(LOCK_N - 1);

    typedef enum logic {
        SEARCH = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t              state, state_d;
    logic [CODE_W-1:0]   r_code, r_prev;
    logic                r_div;
    logic [GCNT_W-1:0]   good_cnt, good_cnt_d;

    logic [DIG_W-1:0]    dig_code, dig_prev, dig_next;
    logic                good;

    logic [DIG_W-1:0]    digit_d;
    logic                valid_d, locked_d, carry_d, err_d;
    logic [ERR_W-1:0]    err_cnt_d;

    // Ring-grey code to BCD digit; anything outside the table decodes to 4'hF.
    function automatic logic [DIG_W-1:0] dig(input logic [CODE_W-1:0] code);
        case (code)
            5'b10001: dig = 4'd0;
            5'b00001: dig = 4'd1;
            5'b00011: dig = 4'd2;
            5'b00010: dig = 4'd3;
            5'b00110: dig = 4'd4;
            5'b00100: dig = 4'd5;
            5'b01100: dig = 4'd6;
            5'b01000: dig = 4'd7;
            5'b11000: dig = 4'd8;
            5'b10000: dig = 4'd9;
            default:  dig = DIG_BAD;
        endcase
    endfunction

    // Stage 1: capture code history and divided clock.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_code <= '0;
            r_prev <= '0;
            r_div  <= 1'b0;
        end else begin
            r_prev <= r_code;
            r_code <= i_cnt;
            r_div  <= i_clk_div;
        end
    end

    // Transition qualification on the stage-1 values.
    always_comb begin
        dig_code = dig(r_code);
        dig_prev = dig(r_prev);
        dig_next = (dig_prev == 4'd9) ? 4'd0 : dig_prev + 4'd1;
        // clk_div is high for digits 5..9 and low for 0..4.
        good     = (dig_code != DIG_BAD) && (dig_prev != DIG_BAD) &&
                   (dig_code == dig_next) && (r_div == (dig_code >= 4'd5));
    end

    // Stage 2 next-state and output logic.
    always_comb begin
        state_d    = state;
        good_cnt_d = good_cnt;
        carry_d    = 1'b0;
        err_d      = 1'b0;
        digit_d    = dig_code;
        valid_d    = (dig_code != DIG_BAD);

        case (state)
            SEARCH: begin
                if (good) begin
                    if (good_cnt == LOCK_LAST) begin
                        state_d    = LOCKED;
                        good_cnt_d = '0;
                    end else begin
                        good_cnt_d = good_cnt + GCNT_W'(1);
                    end
                end else begin
                    good_cnt_d = '0;
                end
            end
            LOCKED: begin
                if (good) begin
                    carry_d = (dig_prev == 4'd9) && (dig_code == 4'd0);
                end else begin
                    err_d      = 1'b1;
                    state_d    = SEARCH;
                    good_cnt_d = '0;
                end
            end
            default: begin
                state_d    = SEARCH;
                good_cnt_d = '0;
            end
        endcase

        locked_d = (state_d == LOCKED);

        // Clear wins over accumulate, but an error in the clearing cycle still counts once.
        err_cnt_d = o_err_cnt;
        if (i_clr_err) begin
            err_cnt_d = err_d ? ERR_W'(1) : '0;
        end else if (err_d && (o_err_cnt != '1)) begin
            err_cnt_d = o_err_cnt + ERR_W'(1);
        end
    end

    // Stage 2 state and output registers.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state     <= SEARCH;
            good_cnt  <= '0;
            o_digit   <= DIG_BAD;
            o_valid   <= 1'b0;
            o_locked  <= 1'b0;
            o_carry   <= 1'b0;
            o_err     <= 1'b0;
            o_err_cnt <= '0;
        end else begin
            state     <= state_d;
            good_cnt  <= good_cnt_d;
            o_digit   <= digit_d;
            o_valid   <= valid_d;
            o_locked  <= locked_d;
            o_carry   <= carry_d;
            o_err     <= err_d;
            o_err_cnt <= err_cnt_d;
        end
    end

endmodule

// File: tb/tb_grey_10_check.sv
// tb_grey_10_check: randomized and directed stimulus for grey_10_check.
//   A reference model pushes the expected outputs of every clock edge into a queue.
//   A separate monitor pops the queue and compares it on the falling edge.
module tb_grey_10_check;

    localparam int unsigned LOCK_N  = 4;
    localparam int unsigned ERR_W   = 2;
    localparam int          ERR_MAX = (1 << ERR_W) - 1;

    logic             i_clk = 1'b0;
    logic             i_rst;
    logic [4:0]       i_cnt;
    logic             i_clk_div;
    logic             i_clr_err;
    logic [3:0]       o_digit;
    logic             o_valid;
    logic             o_locked;
    logic             o_carry;
    logic             o_err;
    logic [ERR_W-1:0] o_err_cnt;

    grey_10_check #(.LOCK_N(LOCK_N), .ERR_W(ERR_W)) dut (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_cnt     (i_cnt),
        .i_clk_div (i_clk_div),
        .i_clr_err (i_clr_err),
        .o_digit   (o_digit),
        .o_valid   (o_valid),
        .o_locked  (o_locked),
        .o_carry   (o_carry),
        .o_err     (o_err),
        .o_err_cnt (o_err_cnt)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        int digit;
        int valid;
        int locked;
        int carry;
        int err;
        int ecnt;
    } exp_t;

    exp_t       exp_q[$];
    logic [4:0] ring [10];
    int         n_checks = 0;
    int         n_pass   = 0;

    // Model state: the last two sampled codes, the last sampled clk_div, lock status.
    logic [4:0] m_code, m_prev;
    logic       m_div;
    int         m_locked, m_streak, m_ecnt;
    int         cur;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    function automatic int dig_of(input logic [4:0] c);
        for (int i = 0; i < 10; i++) if (ring[i] == c) return i;
        return -1;
    endfunction

    task automatic model_reset();
        m_code = '0; m_prev = '0; m_div = 1'b0;
        m_locked = 0; m_streak = 0; m_ecnt = 0;
    endtask

    // Expected outputs after one clock edge that samples (code, div, clr).
    task automatic model_edge(input logic [4:0] code, input logic div, input logic clr);
        exp_t e;
        int dc, dp;
        bit good;
        dc = dig_of(m_code);
        dp = dig_of(m_prev);
        good = (dc >= 0) && (dp >= 0) && (dc == (dp + 1) % 10) && (m_div == (dc >= 5));
        e.carry = 0;
        e.err   = 0;
        if (m_locked != 0) begin
            if (good) e.carry = (dp == 9 && dc == 0) ? 1 : 0;
            else begin
                e.err = 1; m_locked = 0; m_streak = 0;
            end
        end else if (good) begin
            m_streak++;
            if (m_streak == LOCK_N) m_locked = 1;
        end else begin
            m_streak = 0;
        end
        if (clr) m_ecnt = e.err;
        else if (e.err != 0 && m_ecnt < ERR_MAX) m_ecnt++;
        e.digit  = (dc < 0) ? 15 : dc;
        e.valid  = (dc >= 0) ? 1 : 0;
        e.locked = m_locked;
        e.ecnt   = m_ecnt;
        exp_q.push_back(e);
        m_prev = m_code;
        m_code = code;
        m_div  = div;
    endtask

    // Called at posedge+1; returns at the following posedge+1.
    task automatic step(input logic [4:0] code, input logic div, input logic clr);
        i_cnt = code; i_clk_div = div; i_clr_err = clr;
        @(posedge i_clk);
        model_edge(code, div, clr);
        #1;
    endtask

    task automatic legal_n(input int n, input logic clr);
        for (int i = 0; i < n; i++) begin
            cur = (cur + 1) % 10;
            step(ring[cur], (cur >= 5), clr);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_digit"},  int'(o_digit),   15);
        chk({tag, "_valid"},  int'(o_valid),   0);
        chk({tag, "_locked"}, int'(o_locked),  0);
        chk({tag, "_carry"},  int'(o_carry),   0);
        chk({tag, "_err"},    int'(o_err),     0);
        chk({tag, "_errcnt"}, int'(o_err_cnt), 0);
    endtask

    // Asynchronous reset applied between clock edges.
    task automatic do_reset(input string tag);
        i_rst = 1'b1;
        exp_q.delete();
        #1;
        chk_reset_vals(tag);
        repeat (2) @(posedge i_clk);
        #1;
        i_rst = 1'b0;
        model_reset();
    endtask

    // Monitor: compare every expected record against the settled DUT outputs.
    initial begin
        exp_t e;
        forever begin
            @(negedge i_clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("sb_digit",  int'(o_digit),   e.digit);
                chk("sb_valid",  int'(o_valid),   e.valid);
                chk("sb_locked", int'(o_locked),  e.locked);
                chk("sb_carry",  int'(o_carry),   e.carry);
                chk("sb_err",    int'(o_err),     e.err);
                chk("sb_errcnt", int'(o_err_cnt), e.ecnt);
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int carries, errs;
        logic [4:0] bad_code;
        ring = '{5'b10001, 5'b00001, 5'b00011, 5'b00010, 5'b00110,
                 5'b00100, 5'b01100, 5'b01000, 5'b11000, 5'b10000};
        i_rst = 1'b1; i_cnt = '0; i_clk_div = 1'b0; i_clr_err = 1'b0;
        model_reset();
        repeat (2) @(posedge i_clk);
        #1;
        chk_reset_vals("rst0");
        i_rst = 1'b0;

        // T1: clean sequence from digit 0; lock at edge 2+LOCK_N.
        cur = 0;
        step(ring[0], 1'b0, 1'b0);
        legal_n(4, 1'b0);
        chk("t1_not_locked_e5", int'(o_locked), 0);
        legal_n(1, 1'b0);
        chk("t1_locked_e6", int'(o_locked), 1);
        carries = 0;
        for (int i = 0; i < 20; i++) begin
            legal_n(1, 1'b0);
            carries += int'(o_carry);
        end
        chk("t1_carries_20", carries, 2);
        chk("t1_errcnt", int'(o_err_cnt), 0);

        // T2: single illegal code while locked.
        cur = (cur + 1) % 10;
        step(5'b00101, 1'b0, 1'b0);
        legal_n(1, 1'b0);
        chk("t2_valid", int'(o_valid), 0);
        chk("t2_digit", int'(o_digit), 15);
        chk("t2_err", int'(o_err), 1);
        chk("t2_errcnt", int'(o_err_cnt), 1);
        chk("t2_locked", int'(o_locked), 0);
        legal_n(4, 1'b0);
        chk("t2_not_relocked", int'(o_locked), 0);
        legal_n(1, 1'b0);
        chk("t2_relocked", int'(o_locked), 1);

        // T3: skip 3 -> 5.
        while (cur != 3) legal_n(1, 1'b0);
        cur = 5;
        step(ring[5], 1'b1, 1'b0);
        legal_n(1, 1'b0);
        chk("t3_err", int'(o_err), 1);
        chk("t3_carry", int'(o_carry), 0);
        chk("t3_errcnt", int'(o_err_cnt), 2);
        legal_n(12, 1'b0);

        // T4: wrong clk_div phase on digit 7.
        while (cur != 6) legal_n(1, 1'b0);
        cur = 7;
        step(ring[7], 1'b0, 1'b0);
        legal_n(1, 1'b0);
        chk("t4_err", int'(o_err), 1);
        chk("t4_locked", int'(o_locked), 0);
        chk("t4_errcnt", int'(o_err_cnt), 3);
        legal_n(12, 1'b0);

        // T5: held code saturates the counter; clear with and without an error.
        step(ring[cur], (cur >= 5), 1'b0);
        legal_n(1, 1'b0);
        chk("t5_sat_err", int'(o_err), 1);
        chk("t5_sat_cnt", int'(o_err_cnt), 3);
        legal_n(12, 1'b0);
        cur = (cur + 1) % 10;
        step(5'b11111, 1'b0, 1'b0);
        legal_n(1, 1'b1);
        chk("t5_clr_with_err", int'(o_err_cnt), 1);
        legal_n(1, 1'b1);
        chk("t5_clr_alone", int'(o_err_cnt), 0);
        legal_n(12, 1'b0);

        // Randomized disturbances against the model.
        for (int i = 0; i < 400; i++) begin
            logic clr;
            int r;
            clr = ($urandom_range(0, 15) == 0);
            r = $urandom_range(0, 19);
            case (r)
                0: begin
                    do bad_code = 5'($urandom); while (dig_of(bad_code) >= 0);
                    step(bad_code, 1'($urandom), clr);
                end
                1: begin cur = (cur + 2) % 10; step(ring[cur], (cur >= 5), clr); end
                2: begin cur = (cur + 1) % 10; step(ring[cur], (cur < 5), clr); end
                3: step(ring[cur], (cur >= 5), clr);
                default: legal_n(1, clr);
            endcase
        end
        legal_n(12, 1'b0);
        chk("rand_relocked", int'(o_locked), 1);

        // T6: emulated counter start-up (ZERO held with clk_div=1), then reset while locked.
        do_reset("t6_rst_a");
        cur = 0;
        errs = 0;
        repeat (3) begin
            step(ring[0], 1'b1, 1'b0);
            errs += int'(o_err);
        end
        for (int i = 0; i < 20; i++) begin
            legal_n(1, 1'b0);
            errs += int'(o_err);
        end
        chk("t6_startup_errs", errs, 0);
        chk("t6_locked_before_rst", int'(o_locked), 1);
        do_reset("t6_rst_b");
        errs = 0;
        for (int i = 0; i < 15; i++) begin
            legal_n(1, 1'b0);
            errs += int'(o_err);
        end
        chk("t6_relock_errs", errs, 0);
        chk("t6_relocked", int'(o_locked), 1);

        repeat (3) @(negedge i_clk);
        chk("drain", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
